// File: rtl/video_pkg.sv
// Shared video constants: default pixel width, color constants and RGB field offsets.
package video_pkg;

   localparam int PIX_W_DEF = 24;
   localparam int COMP_W    = 8;

   // Field offsets inside a packed {red, grn, blu} pixel
   localparam int RED_LSB = 16;
   localparam int GRN_LSB = 8;
   localparam int BLU_LSB = 0;

   localparam logic [PIX_W_DEF-1:0] BLACK  = 24'h000000;
   localparam logic [PIX_W_DEF-1:0] WHITE  = 24'hFFFFFF;
   localparam logic [PIX_W_DEF-1:0] BG_DEF = BLACK;

   // Pack three color components into one pixel
   function automatic logic [PIX_W_DEF-1:0] rgb(input logic [COMP_W-1:0] r,
                                                input logic [COMP_W-1:0] g,
                                                input logic [COMP_W-1:0] b);
      return {r, g, b};
   endfunction

endpackage

// File: rtl/video_source_arbiter_if.sv
// Encoder/source bundle around the arbiter: i_* flow into the arbiter, o_* flow out.
interface video_source_arbiter_if
   import video_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int PIX_W   = PIX_W_DEF
);

   logic [NUM_SRC-1:0]       i_req;
   logic                     i_rd;
   logic                     i_newline;
   logic                     i_newframe;
   logic [NUM_SRC*PIX_W-1:0] i_pixel;

   logic [NUM_SRC-1:0]       o_rd;
   logic [NUM_SRC-1:0]       o_newline;
   logic [NUM_SRC-1:0]       o_newframe;
   logic [PIX_W-1:0]         o_pixel;
   logic [NUM_SRC-1:0]       o_grant;
   logic                     o_active;

   // Encoder plus sources side
   modport master (
      output i_req, i_rd, i_newline, i_newframe, i_pixel,
      input  o_rd, o_newline, o_newframe, o_pixel, o_grant, o_active
   );

   // Arbiter side
   modport slave (
      input  i_req, i_rd, i_newline, i_newframe, i_pixel,
      output o_rd, o_newline, o_newframe, o_pixel, o_grant, o_active
   );

endinterface

// File: rtl/video_source_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above i_start, wrapping modulo NUM_SRC.
module rr_pick #(
   parameter  int NUM_SRC = 4,
   localparam int IW      = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IW-1:0]      i_start,
   output logic               o_found,
   output logic [IW-1:0]      o_idx
);

   logic [IW-1:0] w_cand;

   // Walk candidates upward from the start; the first hit wins
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_cand = IW'((int'(i_start) + k) % NUM_SRC);
         if (!o_found && i_req[w_cand]) begin
            o_found = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/video_source_arbiter.sv
// Frame-synchronous arbiter sharing one encoder pixel stream among NUM_SRC sources.
// Ownership only moves on i_newframe cycles so frames are never torn.
module video_source_arbiter
   import video_pkg::*;
#(
   parameter int                NUM_SRC    = 4,
   parameter int                PIX_W      = PIX_W_DEF,
   parameter int                MIN_FRAMES = 2,
   parameter logic [PIX_W-1:0]  BG_COLOR   = PIX_W'(BG_DEF)
) (
   input  logic                  clk_25mhz,
   input  logic                  reset,
   video_source_arbiter_if.slave bus
);

   localparam int IW = $clog2(NUM_SRC);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);
   localparam logic [7:0]    HOLD_LIM = 8'(MIN_FRAMES - 1);

   logic [IW-1:0] r_owner;
   logic          r_valid;
   logic [7:0]    r_hold;
   logic [IW-1:0] r_rr;

   logic [IW-1:0] w_owner_nx;
   logic          w_valid_nx;
   logic [7:0]    w_hold_nx;
   logic [IW-1:0] w_rr_nx;
   logic [IW-1:0] w_start;
   logic          w_found;
   logic [IW-1:0] w_pick;
   logic          w_take;
   logic [NUM_SRC-1:0] w_grant;

   // Search starts after the owner when owned, at the rr pointer when idle
   always_comb begin
      w_start = r_rr;
      if (r_valid)
         w_start = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
   end

   rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
      .i_req   (bus.i_req),
      .i_start (w_start),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   // Next-state arbitration, evaluated only on new-frame cycles
   always_comb begin
      w_owner_nx = r_owner;
      w_valid_nx = r_valid;
      w_hold_nx  = r_hold;
      w_rr_nx    = r_rr;
      w_take     = 1'b0;
      if (bus.i_newframe) begin
         if (!r_valid) begin
            w_take = w_found;
         end else if (!bus.i_req[r_owner]) begin
            // Owner released: hand over, or fall idle (rr already points past it)
            w_take = w_found;
            if (!w_found) begin
               w_valid_nx = 1'b0;
               w_hold_nx  = '0;
            end
         end else if (r_hold < HOLD_LIM) begin
            w_hold_nx = r_hold + 8'd1;
         end else begin
            // Hold expired: yield only to a different requester, else keep (counter stays put)
            w_take = w_found && (w_pick != r_owner);
         end
         if (w_take) begin
            w_owner_nx = w_pick;
            w_valid_nx = 1'b1;
            w_hold_nx  = '0;
            w_rr_nx    = (w_pick == LAST_IDX) ? '0 : w_pick + 1'b1;
         end
      end
   end

   // Arbitration state register with synchronous reset
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         r_owner <= '0;
         r_valid <= 1'b0;
         r_hold  <= '0;
         r_rr    <= '0;
      end else begin
         r_owner <= w_owner_nx;
         r_valid <= w_valid_nx;
         r_hold  <= w_hold_nx;
         r_rr    <= w_rr_nx;
      end
   end

   // Grant decode, zero-latency strobe forwarding and pixel mux
   always_comb begin
      w_grant = '0;
      if (r_valid)
         w_grant[r_owner] = 1'b1;
   end

   assign bus.o_grant    = w_grant;
   assign bus.o_active   = r_valid;
   assign bus.o_rd       = {NUM_SRC{bus.i_rd}} & w_grant;
   assign bus.o_newline  = {NUM_SRC{bus.i_newline}};
   assign bus.o_newframe = {NUM_SRC{bus.i_newframe}};
   assign bus.o_pixel    = r_valid ? bus.i_pixel[r_owner*PIX_W +: PIX_W] : BG_COLOR;

   // The grant is never more than one source
   a_grant_onehot0: assert property (@(posedge clk_25mhz) $onehot0(bus.o_grant));

endmodule

// File: tb/tb_video_source_arbiter.sv
// Randomized bench for video_source_arbiter with a frame-level reference model.
module tb_video_source_arbiter;

   localparam int NS  = 4;
   localparam int PW  = 24;
   localparam int MIN = 2;
   localparam logic [PW-1:0] BG = 24'h000000;

   logic clk_25mhz = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model: owner index (-1 idle), frames owned so far, round-robin start
   int m_owner = -1;
   int m_held  = 0;
   int m_rr    = 0;

   always #20 clk_25mhz = ~clk_25mhz;

   video_source_arbiter_if #(.NUM_SRC(NS), .PIX_W(PW)) bus ();

   video_source_arbiter #(
      .NUM_SRC(NS), .PIX_W(PW), .MIN_FRAMES(MIN), .BG_COLOR(BG)
   ) dut (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .bus       (bus)
   );

   function automatic int search(input logic [NS-1:0] req, input int from, input int excl);
      int c;
      for (int k = 0; k < NS; k++) begin
         c = (from + k) % NS;
         if (req[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic model_give(input int c);
      m_owner = c;
      m_held  = 1;
      m_rr    = (c + 1) % NS;
   endtask

   // One frame boundary of the arbitration policy
   task automatic model_frame(input logic [NS-1:0] req);
      int c;
      if (m_owner < 0) begin
         c = search(req, m_rr, -1);
         if (c >= 0) model_give(c);
      end else if (!req[m_owner]) begin
         c = search(req, (m_owner + 1) % NS, -1);
         if (c >= 0) model_give(c);
         else m_owner = -1;
      end else if (m_held < MIN) begin
         m_held++;
      end else begin
         c = search(req, (m_owner + 1) % NS, m_owner);
         if (c >= 0) model_give(c);
         else m_held++;
      end
   endtask

   function automatic logic [NS-1:0] eg();
      logic [NS-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic [PW-1:0] ep();
      if (m_owner < 0) return BG;
      return bus.i_pixel[m_owner*PW +: PW];
   endfunction

   task automatic rand_pix();
      for (int k = 0; k < NS; k++) bus.i_pixel[k*PW +: PW] = PW'($urandom);
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge
   task automatic step();
      @(posedge clk_25mhz);
      if (reset) begin
         m_owner = -1; m_held = 0; m_rr = 0;
      end else if (bus.i_newframe) begin
         model_frame(bus.i_req);
      end
      #1;
   endtask

   task automatic pulse_frame(input logic [NS-1:0] req);
      bus.i_req = req;
      bus.i_newframe = 1'b1;
      step();
      bus.i_newframe = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      bus.i_req = '0; bus.i_rd = 1'b0; bus.i_newline = 1'b0; bus.i_newframe = 1'b0;
      rand_pix();
      reset = 1'b1;
      step();
      step();
      bus.i_rd = 1'b1;
      #1;
      n_checks++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.o_grant); end
      n_checks++; if (bus.o_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", bus.o_active); end
      n_checks++; if (bus.o_pixel !== BG) begin n_fail++; $display("FAIL reset_pixel: got %h expected %h", bus.o_pixel, BG); end
      n_checks++; if (bus.o_rd !== 4'b0000) begin n_fail++; $display("FAIL reset_rd: got %b expected 0000", bus.o_rd); end
      bus.i_rd = 1'b0;
      reset = 1'b0;
      #1;
   endtask

   task automatic test_single();
      rand_pix();
      pulse_frame(4'b0001);
      bus.i_rd = 1'b1;
      #1;
      n_checks++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", bus.o_grant); end
      n_checks++; if (bus.o_rd !== 4'b0001) begin n_fail++; $display("FAIL single_rd: got %b expected 0001", bus.o_rd); end
      n_checks++; if (bus.o_pixel !== bus.i_pixel[23:0]) begin n_fail++; $display("FAIL single_pixel: got %h expected %h", bus.o_pixel, bus.i_pixel[23:0]); end
      n_checks++; if (bus.o_active !== 1'b1) begin n_fail++; $display("FAIL single_active: got %b expected 1", bus.o_active); end
      bus.i_rd = 1'b0;
      #1;
      n_checks++; if (bus.o_rd !== 4'b0000) begin n_fail++; $display("FAIL single_rd_idle: got %b expected 0000", bus.o_rd); end
   endtask

   task automatic test_idle();
      do_reset();
      for (int f = 0; f < 3; f++) begin
         bus.i_req = '0; bus.i_newframe = 1'b1; bus.i_newline = 1'b1; bus.i_rd = 1'b1;
         rand_pix();
         #1;
         n_checks++; if (bus.o_newframe !== 4'b1111) begin n_fail++; $display("FAIL idle_newframe: got %b expected 1111", bus.o_newframe); end
         n_checks++; if (bus.o_newline !== 4'b1111) begin n_fail++; $display("FAIL idle_newline: got %b expected 1111", bus.o_newline); end
         step();
         bus.i_newframe = 1'b0; bus.i_newline = 1'b0;
         #1;
         n_checks++; if (bus.o_grant !== 4'b0000 || bus.o_active !== 1'b0) begin n_fail++; $display("FAIL idle_grant: got %b/%b expected 0000/0", bus.o_grant, bus.o_active); end
         n_checks++; if (bus.o_pixel !== 24'h000000) begin n_fail++; $display("FAIL idle_pixel: got %h expected 000000", bus.o_pixel); end
         n_checks++; if (bus.o_rd !== 4'b0000) begin n_fail++; $display("FAIL idle_rd: got %b expected 0000", bus.o_rd); end
         n_checks++; if (bus.o_newframe !== 4'b0000) begin n_fail++; $display("FAIL idle_newframe_low: got %b expected 0000", bus.o_newframe); end
         step(); step();
      end
      bus.i_rd = 1'b0;
   endtask

   task automatic test_rotation();
      int exp_own[6] = '{0, 0, 1, 1, 0, 0};
      logic [NS-1:0] want;
      do_reset();
      for (int f = 0; f < 6; f++) begin
         pulse_frame(4'b0011);
         step(); step();
         want = '0;
         want[exp_own[f]] = 1'b1;
         n_checks++; if (bus.o_grant !== want) begin n_fail++; $display("FAIL rotation_f%0d: got %b expected %b", f, bus.o_grant, want); end
         n_checks++; if (bus.o_grant !== eg()) begin n_fail++; $display("FAIL rotation_model_f%0d: got %b expected %b", f, bus.o_grant, eg()); end
      end
   endtask

   task automatic test_drop();
      logic [NS-1:0] nxt[3] = '{4'b1000, 4'b0001, 4'b0000};
      for (int sc = 0; sc < 3; sc++) begin
         do_reset();
         pulse_frame(4'b0100);
         n_checks++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL drop_own_sc%0d: got %b expected 0100", sc, bus.o_grant); end
         bus.i_req = 4'b0000;
         step(); step(); step(); step();
         n_checks++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL drop_midframe_sc%0d: got %b expected 0100", sc, bus.o_grant); end
         pulse_frame(nxt[sc]);
         n_checks++; if (bus.o_grant !== nxt[sc]) begin n_fail++; $display("FAIL drop_handover_sc%0d: got %b expected %b", sc, bus.o_grant, nxt[sc]); end
      end
   endtask

   task automatic test_toggle();
      int bad;
      do_reset();
      pulse_frame(4'b0010);
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         bus.i_req = 4'($urandom);
         step();
         if (bus.o_grant !== 4'b0010) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL toggle_hold: got %0d cycles off-grant expected 0", bad); end
      pulse_frame(4'b0100);
      n_checks++; if (bus.o_grant !== 4'b0100) begin n_fail++; $display("FAIL toggle_frame_sample: got %b expected 0100", bus.o_grant); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_frame(4'b0010);
      step(); step(); step();
      n_checks++; if (bus.o_grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_own: got %b expected 0010", bus.o_grant); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.i_rd = 1'b1;
      rand_pix();
      #1;
      n_checks++; if (bus.o_grant !== 4'b0000 || bus.o_active !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: got %b/%b expected 0000/0", bus.o_grant, bus.o_active); end
      n_checks++; if (bus.o_rd !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rd: got %b expected 0000", bus.o_rd); end
      n_checks++; if (bus.o_pixel !== BG) begin n_fail++; $display("FAIL rstmid_pixel: got %h expected %h", bus.o_pixel, BG); end
      bus.i_rd = 1'b0;
      step(); step();
      n_checks++; if (bus.o_grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_stay_idle: got %b expected 0000", bus.o_grant); end
      pulse_frame(4'b0010);
      n_checks++; if (bus.o_grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_regrant: got %b expected 0010", bus.o_grant); end
      pulse_frame(4'b0011);
      n_checks++; if (bus.o_grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_hold_fresh: got %b expected 0010", bus.o_grant); end
      pulse_frame(4'b0011);
      n_checks++; if (bus.o_grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_hold_expire: got %b expected 0001", bus.o_grant); end
   endtask

   // Random frames of 1..6 cycles (length 1 gives back-to-back new-frame strobes)
   task automatic test_back_to_back();
      int len;
      logic [NS-1:0] exp_rd;
      do_reset();
      for (int f = 0; f < 60; f++) begin
         len = $urandom_range(1, 6);
         for (int c = 0; c < len; c++) begin
            bus.i_newframe = (c == 0);
            bus.i_req      = 4'($urandom);
            bus.i_rd       = 1'($urandom);
            bus.i_newline  = 1'($urandom);
            rand_pix();
            #1;
            exp_rd = bus.i_rd ? eg() : 4'b0000;
            n_checks++; if (bus.o_grant !== eg()) begin n_fail++; $display("FAIL rand_grant f%0d c%0d: got %b expected %b", f, c, bus.o_grant, eg()); end
            n_checks++; if (bus.o_active !== (m_owner >= 0)) begin n_fail++; $display("FAIL rand_active f%0d c%0d: got %b", f, c, bus.o_active); end
            n_checks++; if (bus.o_rd !== exp_rd) begin n_fail++; $display("FAIL rand_rd f%0d c%0d: got %b expected %b", f, c, bus.o_rd, exp_rd); end
            n_checks++; if (bus.o_pixel !== ep()) begin n_fail++; $display("FAIL rand_pixel f%0d c%0d: got %h expected %h", f, c, bus.o_pixel, ep()); end
            n_checks++; if (bus.o_newframe !== {NS{bus.i_newframe}} || bus.o_newline !== {NS{bus.i_newline}}) begin
               n_fail++; $display("FAIL rand_strobes f%0d c%0d: got %b/%b", f, c, bus.o_newframe, bus.o_newline);
            end
            step();
         end
      end
      bus.i_newframe = 1'b0; bus.i_rd = 1'b0; bus.i_newline = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.i_req = '0; bus.i_rd = 1'b0; bus.i_newline = 1'b0; bus.i_newframe = 1'b0;
      bus.i_pixel = '0;
      test_reset();
      test_single();
      test_idle();
      test_rotation();
      test_drop();
      test_toggle();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/video_source_arbiter.md
Name: video_source_arbiter

Overview:
- Frame-synchronous arbiter that shares the single HDMI encoder pixel stream between NUM_SRC pixel sources, such as the test-pattern generator and future framebuffer or overlay generators.
- Sits between the encoder's read/line/frame strobes and the sources.
  - Forwards pixel-read strobes only to the source that owns the current frame.
  - Muxes that source's pixel to the encoder.
- Ownership changes only at frame boundaries, so no frame is ever torn.

Parameters:
- NUM_SRC, 4, number of pixel sources (2..8).
- PIX_W, 24, pixel width in bits, packed {red, grn, blu}.
- MIN_FRAMES, 2, minimum frames an owner keeps the grant while still requesting (1..255).
- BG_COLOR, 24'h000000, pixel driven when no source owns the frame.

Ports:
- clk_25mhz  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- i_req  in  NUM_SRC  per-source request level (source wants the display)
- i_rd  in  1  encoder pixel-read strobe
- i_newline  in  1  encoder new-line strobe
- i_newframe  in  1  encoder new-frame strobe
- i_pixel  in  NUM_SRC*PIX_W  source pixels; source k occupies bits [k*PIX_W +: PIX_W]
- o_rd  out  NUM_SRC  read strobe per source
- o_newline  out  NUM_SRC  new-line strobe per source
- o_newframe  out  NUM_SRC  new-frame strobe per source
- o_pixel  out  PIX_W  pixel presented to the encoder
- o_grant  out  NUM_SRC  one-hot current owner; all zero means idle
- o_active  out  1  asserted when o_grant is nonzero

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk_25mhz.
- Reset values:
  - o_grant=0, o_active=0.
  - Hold counter=0, rr pointer=0.
  - o_pixel=BG_COLOR.
  - o_rd, o_newline and o_newframe follow their inputs combinationally per the strobe-forwarding rules below (o_rd=0 while idle).
- Strobe forwarding (combinational, zero latency):
  - o_newframe[k]=i_newframe and o_newline[k]=i_newline for every k, so all sources stay frame/line aligned.
  - o_rd[k]=i_rd & o_grant[k]; non-owners never see a read.
- Pixel mux (combinational, zero latency):
  - o_pixel = i_pixel slice of the owner.
  - o_pixel = BG_COLOR when idle.
- Requests are sampled only on cycles with i_newframe=1; i_req changes mid-frame have no effect.
- Arbitration happens on an i_newframe cycle. The new grant registers at the clock edge and is effective from the next cycle.
  - Idle: pick the first requester searching upward from the rr pointer, modulo NUM_SRC.
    - If there are no requesters, stay idle.
  - Owned, owner's i_req=0: release. Pick the next requester searching from owner+1; go idle if none.
  - Owned, owner requesting, hold counter < MIN_FRAMES-1: keep the owner and increment the counter.
  - Owned, owner requesting, hold counter >= MIN_FRAMES-1: search from owner+1 for another requester.
    - If one is found, it takes over.
    - Otherwise the owner keeps the grant and the counter saturates.
- On every grant change: hold counter <= 0 and rr pointer <= new owner+1 (mod NUM_SRC).
- Hold-counter width: 8 bits. It increments only on i_newframe cycles while ownership is unchanged.
- Simultaneous i_newframe with i_rd or i_newline: forwarding uses the pre-edge grant. The arbitration result applies from the next cycle.
- Reset mid-frame:
  - Grant clears immediately at the edge; o_rd goes to all zeros and o_pixel to BG_COLOR from the next cycle.
  - Arbitration resumes at the next i_newframe.
- Invariant: o_grant is always one-hot or zero; assert this in simulation.

Decomposition:
- Shared package video_pkg holds:
  - PIX_W default;
  - color constants (BLACK, WHITE, BG default);
  - the pixel field slice offsets for red, grn and blu.
- Sub-module rr_pick (combinational): input request vector plus start index; outputs found flag and index of the first set bit at or above the start, with wrap. It is instantiated once.
- The arbiter keeps only the registered state: grant index, valid flag, hold counter and rr pointer.

Test Plan:
- Reset, then i_req=4'b0001 and an i_newframe pulse -> o_grant=0001 from the next cycle; i_rd pulses appear only on o_rd[0]; o_pixel=i_pixel[23:0].
- No requests across 3 frames -> o_grant=0, o_active=0, o_pixel=24'h000000, o_rd all zero, o_newframe broadcast to all 4 sources.
- MIN_FRAMES=2, i_req=4'b0011 held across frames -> owner sequence by frame is src0, src0, src1, src1, src0, …
- Owner src2 drops i_req mid-frame -> still owns until the next i_newframe, then passes to src3 if it is requesting, else src0, else idle.
- i_req toggled between i_newframe pulses -> grant unchanged; only the level at the i_newframe cycle counts.
- reset asserted mid-frame while src1 owns -> o_grant=0 next cycle; a later i_newframe with i_req=4'b0010 regrants src1 with hold counter=0.
